// File: rtl/mips_pkg.sv
// Shared MIPS register-write types: address/data widths and the queued write entry.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wreg;
    logic [DATA_W-1:0]     data;
  } wr_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    return NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/mips_rr_pick2.sv
// Round-robin selector: up to limit_i grants for nonzero-register requests, scan starting at rr_ptr_i.
// Register-0 requests are granted whenever reached and never occupy a grant slot; purely combinational.
module mips_rr_pick2 #(
  parameter int NUM_REQ = 3,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [NUM_REQ-1:0] zero_i,
  input  logic [PW-1:0]      rr_ptr_i,
  input  logic [1:0]         limit_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               first_vld_o,
  output logic [PW-1:0]      first_idx_o,
  output logic               second_vld_o,
  output logic [PW-1:0]      second_idx_o,
  output logic               any_o,
  output logic [PW-1:0]      next_rr_o
);

  always_comb begin
    int          pos;
    logic [PW-1:0] idx;
    logic [1:0]  nz;
    grant_o      = '0;
    first_vld_o  = 1'b0;
    first_idx_o  = '0;
    second_vld_o = 1'b0;
    second_idx_o = '0;
    any_o        = 1'b0;
    next_rr_o    = rr_ptr_i;
    nz           = 2'd0;
    pos          = 0;
    idx          = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(rr_ptr_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = PW'(pos);
      if (valid_i[idx] && (zero_i[idx] || (nz < limit_i))) begin
        grant_o[idx] = 1'b1;
        any_o        = 1'b1;
        next_rr_o    = (pos == NUM_REQ - 1) ? '0 : PW'(pos + 1);
        if (!zero_i[idx]) begin
          // First nonzero grant in scan order is the older write.
          if (nz == 2'd0) begin
            first_vld_o = 1'b1;
            first_idx_o = idx;
          end else begin
            second_vld_o = 1'b1;
            second_idx_o = idx;
          end
          nz = nz + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/mips_regwrite_arbiter.sv
// Register-file write arbiter: round-robin 2 grants/cycle into a DEPTH FIFO, drained 2/cycle to two ports, 1-cycle min latency.
// req_ready drops when the queue lacks room, on flush and on rst. MIPS_REGWR_SCOREBOARD_EN enables pending_mask.
module mips_regwrite_arbiter
  import mips_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [REG_ADDR_W*NUM_REQ-1:0]  req_reg,
  input  logic [DATA_W*NUM_REQ-1:0]      req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           signal_reg_write_1,
  output logic [REG_ADDR_W-1:0]          write_reg_1,
  output logic [DATA_W-1:0]              write_data_1,
  output logic                           signal_reg_write_2,
  output logic [REG_ADDR_W-1:0]          write_reg_2,
  output logic [DATA_W-1:0]              write_data_2,
  output logic [NUM_REGS-1:0]            pending_mask,
  output logic [$clog2(DEPTH):0]         count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  wr_entry_t           mem_q [DEPTH];
  wr_entry_t           mem_d [DEPTH];
  logic [AW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic [PW-1:0]       rr_q, rr_d;

  logic [REG_ADDR_W-1:0] rreg [NUM_REQ];
  logic [DATA_W-1:0]     rdat [NUM_REQ];
  logic [NUM_REQ-1:0]    rzero;

  logic                active;
  logic [CW-1:0]       free;
  logic [1:0]          limit, pop, enq;
  logic                first_vld, second_vld, any_grant;
  logic [PW-1:0]       first_idx, second_idx, next_rr;
  logic [AW-1:0]       head_p1, tail_p1;
  logic                p1_vld, p2_vld;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign rreg[i]  = req_reg[REG_ADDR_W*i +: REG_ADDR_W];
    assign rdat[i]  = req_data[DATA_W*i +: DATA_W];
    assign rzero[i] = (rreg[i] == '0);
  end

  // Room is judged on the registered count only; slots freed by this cycle's drain are not reused.
  assign active = !rst && !flush;
  assign free   = CW'(DEPTH) - count_q;
  assign limit  = !active ? 2'd0 : ((free >= CW'(2)) ? 2'd2 : free[1:0]);

  mips_rr_pick2 #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .valid_i      (req_valid & {NUM_REQ{active}}),
    .zero_i       (rzero),
    .rr_ptr_i     (rr_q),
    .limit_i      (limit),
    .grant_o      (req_ready),
    .first_vld_o  (first_vld),
    .first_idx_o  (first_idx),
    .second_vld_o (second_vld),
    .second_idx_o (second_idx),
    .any_o        (any_grant),
    .next_rr_o    (next_rr)
  );

  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);
  assign p1_vld  = active && (count_q >= CW'(1));
  assign p2_vld  = active && (count_q >= CW'(2));

  assign signal_reg_write_1 = p1_vld;
  assign write_reg_1        = p1_vld ? mem_q[head_q].wreg  : '0;
  assign write_data_1       = p1_vld ? mem_q[head_q].data  : '0;
  assign signal_reg_write_2 = p2_vld;
  assign write_reg_2        = p2_vld ? mem_q[head_p1].wreg : '0;
  assign write_data_2       = p2_vld ? mem_q[head_p1].data : '0;
  assign count              = count_q;

  always_comb begin
    pop = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
    enq = {1'b0, first_vld} + {1'b0, second_vld};
    mem_d = mem_q;
    if (first_vld)  mem_d[tail_q]  = '{wreg: rreg[first_idx],  data: rdat[first_idx]};
    if (second_vld) mem_d[tail_p1] = '{wreg: rreg[second_idx], data: rdat[second_idx]};
    head_d  = head_q + AW'(pop);
    tail_d  = tail_q + AW'(enq);
    count_d = count_q - CW'(pop) + CW'(enq);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    rr_d = any_grant ? next_rr : rr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rr_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rr_q    <= rr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef MIPS_REGWR_SCOREBOARD_EN
  logic [NUM_REGS-1:0] pend_q, pend_d;

  // Mask reflects the queue contents as they will stand after this edge.
  always_comb begin
    logic [AW-1:0] off;
    pend_d = '0;
    off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - head_d;
      if ({1'b0, off} < count_d) pend_d = pend_d | reg_onehot(mem_d[AW'(i)].wreg);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign pending_mask = pend_q;
`else
  assign pending_mask = '0;
`endif

endmodule
